// File: rtl/uart_port_ctrl_pkg.sv
// Shared definitions for the UART port controller.
// Holds the FSM state encoding and the default strobe pulse width.
// No ports; imported by uart_port_ctrl.
package uart_port_ctrl_pkg;

    // Default width, in clk cycles, of each rdn/wrn low pulse.
    localparam int PULSE_CYC_DEFAULT = 2;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RD_WAIT  = 4'd1,
        ST_RD_PULSE = 4'd2,
        ST_RD_END   = 4'd3,
        ST_WR_SETUP = 4'd4,
        ST_WR_PULSE = 4'd5,
        ST_WR_HOLD  = 4'd6,
        ST_WR_TBRE  = 4'd7,
        ST_WR_TSRE  = 4'd8,
        ST_DONE     = 4'd9
    } state_e;

endpackage

// File: rtl/uart_port_ctrl.sv
// UART port controller: sequences single-byte reads and writes to an external
// UART chip that shares the low byte of the RAM1 data bus.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   rd_req, wr_req      level requests, only sampled in IDLE (read wins)
//   wr_data[7:0]        byte to write, latched into bus_dout on acceptance
//   rd_data[7:0]        last byte read; held until the next read completes
//   busy, done          busy outside IDLE; done is a one-cycle completion pulse
//   data_ready          UART chip has a received byte
//   tbre, tsre          UART transmit buffer / shift register empty
//   rdn, wrn            active-low read/write strobes to the UART chip
//   bus_din[7:0]        low byte of the shared bus (read path)
//   bus_dout[7:0]       value the top level drives onto the bus
//   bus_drive           enables the bus_dout tristate in the top level
//   ram1_dis            keeps RAM1 off the bus while the port is busy
//   dbg_state_o[3:0]    current FSM state, for observation only
//
// Handshake: a request is accepted on the rising edge where the FSM is in IDLE
// and the request level is high; it is then ignored until done has pulsed and
// the FSM is back in IDLE. There is no back-pressure beyond busy.
module uart_port_ctrl
    import uart_port_ctrl_pkg::*;
#(
    parameter int PULSE_CYC = PULSE_CYC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    input  logic       data_ready,
    input  logic       tbre,
    input  logic       tsre,
    output logic       rdn,
    output logic       wrn,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       bus_drive,
    output logic       ram1_dis,
    output logic [3:0] dbg_state_o
);

    // Exit value of the pulse counter; the counter never counts past it.
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [7:0] bus_dout_q, bus_dout_d;
    logic       rdn_q, rdn_d;
    logic       wrn_q, wrn_d;
    logic       drive_q, drive_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = 4'd0;  // cleared everywhere except while a pulse runs
        rd_data_d  = rd_data_q;
        bus_dout_d = bus_dout_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    state_d = ST_RD_WAIT;
                end else if (wr_req) begin
                    bus_dout_d = wr_data;
                    state_d    = ST_WR_SETUP;
                end
            end
            ST_RD_WAIT: begin
                if (data_ready) state_d = ST_RD_PULSE;
            end
            ST_RD_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    // Capture on the edge that ends the last low cycle.
                    rd_data_d = bus_din;
                    state_d   = ST_RD_END;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RD_END:   state_d = ST_DONE;
            ST_WR_SETUP: state_d = ST_WR_PULSE;
            ST_WR_PULSE: begin
                if (cnt_q == PULSE_LAST) state_d = ST_WR_HOLD;
                else                     cnt_d   = cnt_q + 4'd1;
            end
            ST_WR_HOLD: state_d = ST_WR_TBRE;
            ST_WR_TBRE: begin
                if (tbre) state_d = ST_WR_TSRE;
            end
            ST_WR_TSRE: begin
                if (tsre) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so they
        // switch on the same edge as the state and cannot glitch.
        rdn_d   = (state_d != ST_RD_PULSE);
        wrn_d   = (state_d != ST_WR_PULSE);
        drive_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
                  (state_d == ST_WR_HOLD);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            rd_data_q  <= 8'h00;
            bus_dout_q <= 8'h00;
            rdn_q      <= 1'b1;
            wrn_q      <= 1'b1;
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            bus_dout_q <= bus_dout_d;
            rdn_q      <= rdn_d;
            wrn_q      <= wrn_d;
            drive_q    <= drive_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign bus_dout    = bus_dout_q;
    assign rdn         = rdn_q;
    assign wrn         = wrn_q;
    assign bus_drive   = drive_q;
    assign busy        = busy_q;
    assign ram1_dis    = busy_q;  // RAM1 is kept off the bus whenever busy
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_port_ctrl.sv
// Self-checking bench for uart_port_ctrl (PULSE_CYC = 2).
// A transaction-level model predicts every output each cycle; directed
// scenarios pin the model with hand-computed values; a random phase follows.
module tb_uart_port_ctrl;

    localparam int P = 2;

    // ---------------- clock / reset / signals ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       rd_req, wr_req;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       busy, done;
    logic       data_ready, tbre, tsre;
    logic       rdn, wrn;
    logic [7:0] bus_din, bus_dout;
    logic       bus_drive, ram1_dis;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    uart_port_ctrl #(.PULSE_CYC(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .rdn        (rdn),
        .wrn        (wrn),
        .bus_din    (bus_din),
        .bus_dout   (bus_dout),
        .bus_drive  (bus_drive),
        .ram1_dis   (ram1_dis),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transaction is a phase plus the number of cycles left in its fixed
    // timeline. Read timeline: P strobe cycles then one recovery cycle.
    // Write timeline: setup, P strobe cycles, hold.
    typedef enum int {M_IDLE, M_RWAIT, M_RSEQ, M_WSEQ, M_WTBRE, M_WTSRE, M_DONE} mph_e;
    mph_e       ph = M_IDLE;
    int         left = 0;
    logic [7:0] m_rd = 8'h00;
    logic [7:0] m_dout = 8'h00;
    int         cyc = 0;

    task automatic model_step();
        case (ph)
            M_IDLE: begin
                if (rd_req) ph = M_RWAIT;
                else if (wr_req) begin
                    m_dout = wr_data;
                    ph     = M_WSEQ;
                    left   = P + 2;
                end
            end
            M_RWAIT: if (data_ready) begin ph = M_RSEQ; left = P + 1; end
            M_RSEQ: begin
                if (left == 2) m_rd = bus_din;
                left--;
                if (left == 0) ph = M_DONE;
            end
            M_WSEQ: begin
                left--;
                if (left == 0) ph = M_WTBRE;
            end
            M_WTBRE: if (tbre) ph = M_WTSRE;
            M_WTSRE: if (tsre) ph = M_DONE;
            M_DONE:  ph = M_IDLE;
            default: ph = M_IDLE;
        endcase
    endtask

    // ---------------- per-cycle monitor ----------------
    int         mon_rdn, mon_wrn, mon_drive, mon_busy, mon_done, mon_done_cyc, mon_dout_bad;
    logic [7:0] mon_dout_exp = 8'h00;

    task automatic clr_mon();
        mon_rdn = 0; mon_wrn = 0; mon_drive = 0; mon_busy = 0;
        mon_done = 0; mon_done_cyc = -1; mon_dout_bad = 0;
    endtask

    initial begin
        logic [21:0] exp_v, act_v;
        logic        e_rdn, e_wrn, e_drv;
        clr_mon();
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                ph = M_IDLE; left = 0; m_rd = 8'h00; m_dout = 8'h00;
            end else begin
                model_step();
            end
            #1;
            e_rdn = !(ph == M_RSEQ && left >= 2);
            e_wrn = !(ph == M_WSEQ && left >= 2 && left <= P + 1);
            e_drv = (ph == M_WSEQ);
            exp_v = {ph != M_IDLE, ph != M_IDLE, e_rdn, e_wrn, e_drv, ph == M_DONE, m_rd, m_dout};
            act_v = {busy, ram1_dis, rdn, wrn, bus_drive, done, rd_data, bus_dout};
            check("cycle_outputs{busy,ram1_dis,rdn,wrn,drive,done,rd_data,bus_dout}", act_v, exp_v);
            check("strobe_exclusive", {31'd0, (!rdn && (!wrn || bus_drive))}, 32'd0);
            if (!rdn) mon_rdn++;
            if (!wrn) mon_wrn++;
            if (busy) mon_busy++;
            if (bus_drive) begin
                mon_drive++;
                if (bus_dout !== mon_dout_exp) mon_dout_bad++;
            end
            if (done) begin
                mon_done++;
                mon_done_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        rd_req = 1'b0; wr_req = 1'b0; wr_data = 8'h00;
        data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0; bus_din = 8'h00;
    endtask

    task automatic wait_done(input int bound, input string name);
        int k = 0;
        while (mon_done == 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (mon_done == 0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc, rise, k;
        logic [21:0] rst_exp;
        rst = 1'b1;
        idle_inputs();
        settle(3);
        rst_exp = {6'b001100, 16'h0000};
        check("reset_state", {busy, ram1_dis, rdn, wrn, bus_drive, done, rd_data, bus_dout}, rst_exp);
        rst = 1'b0;
        settle(2);

        // Basic read, data already available.
        data_ready = 1'b1; bus_din = 8'h5A; clr_mon(); acc = cyc; rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
        wait_done(20, "rd_basic");
        settle(1);
        check("rd_basic_rdn_low_cycles", mon_rdn, 2);
        check("rd_basic_latency", mon_done_cyc - acc, 5);
        check("rd_basic_rd_data", rd_data, 8'h5A);
        check("rd_basic_done_count", mon_done, 1);

        // Write with tbre held low for 10 cycles.
        idle_inputs(); tsre = 1'b1; wr_data = 8'hC3; mon_dout_exp = 8'hC3; clr_mon(); wr_req = 1'b1;
        @(negedge clk); wr_req = 1'b0; wr_data = 8'h00;
        settle(9);
        tbre = 1'b1; rise = cyc;
        wait_done(20, "wr_basic");
        settle(1);
        check("wr_basic_wrn_low_cycles", mon_wrn, 2);
        check("wr_basic_drive_cycles", mon_drive, P + 2);
        check("wr_basic_bus_dout_bad", mon_dout_bad, 0);
        check("wr_basic_done_after_tsre", mon_done_cyc - rise, 2);
        check("wr_basic_no_rdn", mon_rdn, 0);

        // Simultaneous requests: read wins.
        idle_inputs(); data_ready = 1'b1; bus_din = 8'hA5; wr_data = 8'h11; clr_mon();
        rd_req = 1'b1; wr_req = 1'b1;
        @(negedge clk); rd_req = 1'b0; wr_req = 1'b0;
        wait_done(20, "both_req");
        settle(2);
        check("both_req_wrn_low", mon_wrn, 0);
        check("both_req_drive", mon_drive, 0);
        check("both_req_rdn_low", mon_rdn, 2);
        check("both_req_rd_data", rd_data, 8'hA5);
        check("both_req_bus_dout_kept", bus_dout, 8'hC3);

        // Read stalled on data_ready for 20 cycles.
        idle_inputs(); clr_mon(); rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
        settle(19);
        check("rd_stall_busy_cycles", mon_busy, 20);
        check("rd_stall_rdn_low", mon_rdn, 0);
        data_ready = 1'b1; bus_din = 8'h3C;
        wait_done(20, "rd_stall");
        settle(1);
        check("rd_stall_rd_data", rd_data, 8'h3C);
        check("rd_stall_rdn_low_total", mon_rdn, 2);

        // Reset in the middle of the write strobe.
        idle_inputs(); tbre = 1'b1; tsre = 1'b1; wr_data = 8'h96; clr_mon(); wr_req = 1'b1;
        @(negedge clk); wr_req = 1'b0;
        k = 0;
        while (wrn !== 1'b0 && k < 10) begin @(negedge clk); k++; end
        check("rst_mid_reached_pulse", {31'd0, wrn}, 32'd0);
        check("rst_mid_bus_dout_before", bus_dout, 8'h96);
        rst = 1'b1;
        #1;
        check("rst_mid_wrn", {31'd0, wrn}, 32'd1);
        check("rst_mid_drive", {31'd0, bus_drive}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_ram1_dis", {31'd0, ram1_dis}, 32'd0);
        check("rst_mid_bus_dout", bus_dout, 8'h00);
        settle(2);
        rst = 1'b0;
        settle(1);
        wr_data = 8'h69; mon_dout_exp = 8'h69; clr_mon(); wr_req = 1'b1;
        @(negedge clk); wr_req = 1'b0;
        wait_done(20, "wr_after_rst");
        settle(1);
        check("wr_after_rst_wrn_low", mon_wrn, 2);
        check("wr_after_rst_done_count", mon_done, 1);
        check("wr_after_rst_bus_dout_bad", mon_dout_bad, 0);

        // Write request during a read is ignored.
        idle_inputs(); clr_mon(); rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
        settle(3);
        wr_req = 1'b1; wr_data = 8'hEE;
        @(negedge clk); wr_req = 1'b0;
        settle(3);
        data_ready = 1'b1; bus_din = 8'h77;
        wait_done(20, "rd_ignore_wr");
        data_ready = 1'b0;
        settle(10);
        check("rd_ignore_wr_done_count", mon_done, 1);
        check("rd_ignore_wr_wrn_low", mon_wrn, 0);
        check("rd_ignore_wr_drive", mon_drive, 0);
        check("rd_ignore_wr_rd_data", rd_data, 8'h77);

        // Random phase, checked by the per-cycle model compare.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rd_req     = ($urandom_range(0, 7) == 0);
            wr_req     = ($urandom_range(0, 5) == 0);
            data_ready = ($urandom_range(0, 3) != 0);
            tbre       = ($urandom_range(0, 2) != 0);
            tsre       = ($urandom_range(0, 2) != 0);
            bus_din    = 8'($urandom);
            wr_data    = 8'($urandom);
            rst        = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        settle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_port_ctrl.md
UART_PORT_CTRL -- requirements
Module: uart_port_ctrl

Interface
REQ-001 Parameter PULSE_CYC, default 2: width in clk cycles of each rdn/wrn low pulse, legal range 1..15.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rd_req  input  1  level; request to read one byte from the UART chip.
REQ-005 wr_req  input  1  level; request to write wr_data to the UART chip.
REQ-006 wr_data  input  8  byte to transmit; sampled on acceptance.
REQ-007 rd_data  output  8  last byte received; holds until the next read completes.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse on completion of a read or write.
REQ-010 data_ready  input  1  UART chip: received byte available.
REQ-011 tbre / tsre  input  1 each  UART chip: transmit buffer empty / transmit shift register empty.
REQ-012 rdn / wrn  output  1 each  UART chip read/write strobes, active-low.
REQ-013 bus_din  input  8  low byte of the shared ram1 data bus.
REQ-014 bus_dout  output  8  value driven onto the low byte of the shared bus.
REQ-015 bus_drive  output  1  high: the top level enables the bus_dout tristate.
REQ-016 ram1_dis  output  1  high: the top level forces ram1_en high, keeping RAM1 off the bus.

Function
REQ-017 States: IDLE, RD_WAIT, RD_PULSE, RD_END, WR_SETUP, WR_PULSE, WR_HOLD, WR_TBRE, WR_TSRE, DONE.
REQ-018 In IDLE, rd_req=1 takes priority over wr_req when both are high; requests in any other state are ignored.
REQ-019 Read path:
- IDLE+rd_req goes to RD_WAIT.
- RD_WAIT holds until data_ready=1, then goes to RD_PULSE.
- RD_PULSE: rdn=0 for exactly PULSE_CYC cycles; rd_data captures bus_din on the rising edge ending the last pulse cycle.
- RD_END: rdn=1 for 1 cycle, then DONE.
REQ-020 Write path:
- IDLE+wr_req latches wr_data into bus_dout and goes to WR_SETUP.
- WR_SETUP: 1 cycle, wrn=1, bus driven.
- WR_PULSE: wrn=0 for exactly PULSE_CYC cycles.
- WR_HOLD: 1 cycle, wrn=1, bus still driven.
- WR_TBRE: wait for tbre=1.
- WR_TSRE: wait for tsre=1.
- Then DONE.
REQ-021 bus_drive=1 only in WR_SETUP, WR_PULSE and WR_HOLD; bus_drive=0 in every read state.
REQ-022 ram1_dis=busy; busy and ram1_dis are registered and change on the same edge as the state.
REQ-023 DONE lasts exactly 1 cycle with done=1, then returns to IDLE; the earliest next acceptance is the cycle after DONE.
REQ-024 The pulse counter is 4 bits, cleared on entry to each pulse state, and never wraps: exit occurs at count PULSE_CYC-1.
REQ-025 rdn and wrn are never low in the same cycle; rdn is never low while bus_drive=1.
REQ-026 Total read latency from acceptance with data_ready already high is PULSE_CYC+3 cycles to done.
REQ-027 No timeout: RD_WAIT, WR_TBRE and WR_TSRE wait indefinitely.

Reset
REQ-028 Asserting rst, including mid-operation, immediately sets:
- state to IDLE;
- rdn=1, wrn=1, bus_drive=0, ram1_dis=0, busy=0, done=0;
- rd_data=8'h00, bus_dout=8'h00, pulse counter=0.
REQ-029 A strobe pulse in progress is truncated by reset, with no glitch back to low.

Structure
REQ-030 State encodings and the default PULSE_CYC constant live in the shared define file; the bus tristate stays in the top level.
REQ-031 Single module; no sub-module.

Verification
REQ-032 PULSE_CYC=2; data_ready=1, bus_din=8'h5A, rd_req pulse in IDLE -> rdn low 2 cycles, rd_data=8'h5A, done 5 cycles after acceptance.
REQ-033 wr_req with wr_data=8'hC3, tbre held 0 for 10 cycles then 1, tsre=1 -> bus_dout=8'hC3 while bus_drive=1, wrn low 2 cycles, done 1 cycle after tsre is seen.
REQ-034 rd_req=wr_req=1 in IDLE -> read path taken, wrn stays 1, bus_drive stays 0.
REQ-035 rd_req with data_ready=0 for 20 cycles -> busy=1, rdn=1 throughout; data_ready rises -> normal read completes.
REQ-036 rst asserted during WR_PULSE -> wrn=1, bus_drive=0, busy=0 before the next clk edge; new wr_req after release -> full write completes.
REQ-037 wr_req pulse during a read in progress -> ignored; exactly one done and no write strobe.
